traffic_change_gen: RTL and testbench

- Upstream stage of traffic_ctr: produces the single-cycle `change` request that advances the light sequence.
- Two request sources:
  - Manual: a debounced board pushbutton (active-low KEY).
  - Automatic: a 1 Hz-based period timer.
- Also exports a 1 Hz tick and a seconds-remaining count for the display stage.

---
 rtl/traffic_pkg.sv | 21 ++
 rtl/key_debounce.sv | 90 +++++++++
 rtl/traffic_change_gen.sv | 91 +++++++++
 tb/tb_traffic_change_gen.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light controller family:
// the key debounce state encoding and the default system clock rate.
package traffic_pkg;

  localparam int unsigned CLK_HZ_DEFAULT          = 32'd50_000_000;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 32'd1_000_000;
  localparam int unsigned AUTO_PERIOD_S_DEFAULT   = 32'd5;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_e;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus press/release debounce FSM for an active-low key.
// Emits one btn_pulse per accepted press; releases never pulse.
module key_debounce
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic btn_pulse
);

  localparam int unsigned    CW       = cnt_width(DEBOUNCE_CYCLES);
  // The transition fires on the edge where db_cnt would step to DEBOUNCE_CYCLES-1,
  // so a stable level is accepted after exactly DEBOUNCE_CYCLES samples.
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 32'd2);

  logic            sync1_q;
  logic            sync2_q;
  logic            key_s;
  db_state_e       state_q;
  logic [CW-1:0]   db_cnt_q;
  logic            btn_pulse_q;

  assign key_s = sync2_q;

  // Synchronizer, debounce FSM and registered press pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= IDLE;
      db_cnt_q    <= '0;
      btn_pulse_q <= 1'b0;
    end else begin
      sync1_q     <= key_n;
      sync2_q     <= sync1_q;
      btn_pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          db_cnt_q <= '0;
          if (!key_s) begin
            state_q <= PRESS_WAIT;
          end else begin
            state_q <= IDLE;
          end
        end
        PRESS_WAIT: begin
          if (key_s) begin
            state_q  <= IDLE;
            db_cnt_q <= '0;
          end else if (db_cnt_q == CNT_LAST) begin
            state_q     <= PRESSED;
            db_cnt_q    <= '0;
            btn_pulse_q <= 1'b1;
          end else begin
            db_cnt_q <= db_cnt_q + CW'(1);
          end
        end
        PRESSED: begin
          db_cnt_q <= '0;
          if (key_s) begin
            state_q <= RELEASE_WAIT;
          end else begin
            state_q <= PRESSED;
          end
        end
        RELEASE_WAIT: begin
          if (!key_s) begin
            state_q  <= PRESSED;
            db_cnt_q <= '0;
          end else if (db_cnt_q == CNT_LAST) begin
            state_q  <= IDLE;
            db_cnt_q <= '0;
          end else begin
            db_cnt_q <= db_cnt_q + CW'(1);
          end
        end
        default: begin
          state_q  <= IDLE;
          db_cnt_q <= '0;
        end
      endcase
    end
  end

  assign btn_pulse = btn_pulse_q;

endmodule

// File: rtl/traffic_change_gen.sv
// Change-request generator: merges debounced key presses with a periodic
// auto timer into a single-cycle change pulse; exports 1 Hz tick and seconds left.
module traffic_change_gen
  import traffic_pkg::*;
#(
  parameter int unsigned CLK_HZ          = CLK_HZ_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned AUTO_PERIOD_S   = AUTO_PERIOD_S_DEFAULT
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               key_n,
  input  logic                               auto_en,
  output logic                               change,
  output logic                               tick_1hz,
  output logic [$clog2(AUTO_PERIOD_S+1)-1:0] sec_left
);

  localparam int unsigned   PW       = cnt_width(CLK_HZ);
  localparam int unsigned   AW       = cnt_width(AUTO_PERIOD_S);
  localparam int unsigned   SW       = $clog2(AUTO_PERIOD_S + 32'd1);
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_HZ - 32'd1);
  localparam logic [AW-1:0] SEC_LAST = AW'(AUTO_PERIOD_S - 32'd1);
  localparam logic [SW-1:0] SEC_FULL = SW'(AUTO_PERIOD_S);

  logic          btn_pulse_s;
  logic          auto_pulse_s;

  logic [PW-1:0] pre_cnt_q,  pre_cnt_d;
  logic          tick_q,     tick_d;
  logic [AW-1:0] sec_cnt_q,  sec_cnt_d;
  logic [SW-1:0] sec_left_q, sec_left_d;
  logic          change_q,   change_d;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk       (clk),
    .reset     (reset),
    .key_n     (key_n),
    .btn_pulse (btn_pulse_s)
  );

  // Next-state for prescaler, auto timer and the output pulse
  always_comb begin
    tick_d = (pre_cnt_q == PRE_LAST);
    if (tick_d) begin
      pre_cnt_d = '0;
    end else begin
      pre_cnt_d = pre_cnt_q + PW'(1);
    end

    auto_pulse_s = auto_en & tick_q & (sec_cnt_q == SEC_LAST);

    // A manual press restarts the period so the next auto change is a full period away.
    if (!auto_en || btn_pulse_s || auto_pulse_s) begin
      sec_cnt_d = '0;
    end else if (tick_q) begin
      sec_cnt_d = sec_cnt_q + AW'(1);
    end else begin
      sec_cnt_d = sec_cnt_q;
    end

    sec_left_d = SEC_FULL - SW'(sec_cnt_d);

    // Back-to-back sources (auto then press next cycle) collapse into one pulse.
    change_d = (btn_pulse_s | auto_pulse_s) & ~change_q;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt_q  <= '0;
      tick_q     <= 1'b0;
      sec_cnt_q  <= '0;
      sec_left_q <= SEC_FULL;
      change_q   <= 1'b0;
    end else begin
      pre_cnt_q  <= pre_cnt_d;
      tick_q     <= tick_d;
      sec_cnt_q  <= sec_cnt_d;
      sec_left_q <= sec_left_d;
      change_q   <= change_d;
    end
  end

  assign change   = change_q;
  assign tick_1hz = tick_q;
  assign sec_left = sec_left_q;

endmodule

// File: tb/tb_traffic_change_gen.sv
// Directed bench for traffic_change_gen: scoreboard of expected change cycles
// plus direct checks of tick_1hz and sec_left at known cycles.
module tb_traffic_change_gen;

  localparam int unsigned CLK_HZ = 10;
  localparam int unsigned DB     = 4;
  localparam int unsigned AP     = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_n;
  logic       auto_en;
  logic       change;
  logic       tick_1hz;
  logic [1:0] sec_left;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int exp_q[$];
  int r;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  traffic_change_gen #(
    .CLK_HZ          (CLK_HZ),
    .DEBOUNCE_CYCLES (DB),
    .AUTO_PERIOD_S   (AP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .key_n    (key_n),
    .auto_en  (auto_en),
    .change   (change),
    .tick_1hz (tick_1hz),
    .sec_left (sec_left)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard: every change pulse must match the head of the expected-cycle queue
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0] == cyc) begin
      chk("change_pulse", change, 1);
      void'(exp_q.pop_front());
    end else if (change) begin
      chk("unexpected_change", change, 0);
    end
  end

  initial begin
    reset   = 1'b1;
    key_n   = 1'b1;
    auto_en = 1'b0;

    // Reset state
    repeat (3) begin
      @(negedge clk);
      chk("rst_change", change, 0);
      chk("rst_tick", tick_1hz, 0);
      chk("rst_sec_left", sec_left, 3);
    end
    reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      chk("first_tick", tick_1hz, (k == 10));
      chk("idle_sec_left", sec_left, 3);
    end

    // Clean press and release
    step(2);
    key_n = 1'b0;
    exp_q.push_back(cyc + 7);
    step(20);
    key_n = 1'b1;
    step(20);
    chk("manual_sec_left", sec_left, 3);

    // Bounce: three low samples are never enough, then a held press
    for (int rep = 0; rep < 5; rep++) begin
      for (int j = 0; j < 4; j++) begin
        key_n = (j == 3);
        step(1);
      end
    end
    key_n = 1'b0;
    exp_q.push_back(cyc + 7);
    step(20);
    key_n = 1'b1;
    step(20);

    // Auto mode from reset
    auto_en = 1'b1;
    reset   = 1'b1;
    step(2);
    reset = 1'b0;
    r = cyc;
    exp_q.push_back(r + 31);
    exp_q.push_back(r + 61);
    for (int k = 1; k <= 65; k++) begin
      step(1);
      chk("auto_tick", tick_1hz, ((k % 10) == 0));
      chk("auto_sec_left", sec_left, 3 - (((k - 1) / 10) % 3));
    end

    // Manual press during auto, then a press aligned with the auto-due tick
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    r = cyc;
    step(8);
    key_n = 1'b0;
    exp_q.push_back(r + 15);
    exp_q.push_back(r + 41);
    step(6);
    chk("pre_press_sec_left", sec_left, 2);
    step(2);
    chk("post_press_sec_left", sec_left, 3);
    step(5);
    chk("restart_sec_left", sec_left, 2);
    step(7);
    key_n = 1'b1;
    step(36);
    key_n = 1'b0;
    exp_q.push_back(r + 71);
    exp_q.push_back(r + 101);
    step(8);
    chk("aligned_sec_left", sec_left, 3);
    step(12);
    key_n = 1'b1;
    step(26);

    // Reset in the middle of a debounce
    auto_en = 1'b0;
    step(2);
    key_n = 1'b0;
    step(2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    exp_q.push_back(cyc + 7);
    step(20);
    key_n = 1'b1;
    step(20);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
